// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the MIPS core.
// Owns the PC and issues word fetches over a req/gnt + rvalid handshake, one
// request in flight at most. Returned words land in the IF/ID register, or
// in a one-entry skid buffer when decode is stalled. Redirects squash
// everything younger than the redirecting instruction.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [15:0] id_imm16
);

  // FETCH: may request. WAIT: live request in flight. DROP: squashed request in flight.
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  function automatic logic [31:0] pc_inc(input logic [31:0] addr);
    pc_inc = addr + 32'd4;
  endfunction

  logic [1:0]  state_r,         state_nxt_s;
  logic [31:0] pc_r,            pc_nxt_s;
  logic [31:0] fetch_addr_r,    fetch_addr_nxt_s;
  logic        imem_req_r,      imem_req_nxt_s;
  logic        id_valid_r,      id_valid_nxt_s;
  logic [31:0] id_instr_r,      id_instr_nxt_s;
  logic [31:0] id_pc_plus4_r,   id_pc_plus4_nxt_s;
  logic        skid_valid_r,    skid_valid_nxt_s;
  logic [31:0] skid_instr_r,    skid_instr_nxt_s;
  logic [31:0] skid_pc_plus4_r, skid_pc_plus4_nxt_s;

  logic fire_s;
  logic consume_s;

  assign fire_s    = imem_req_r & imem_gnt;
  assign consume_s = id_valid_r & id_ready;

  // Next-state logic: consumption, FSM/response capture, then redirect override.
  always_comb begin
    state_nxt_s         = state_r;
    pc_nxt_s            = pc_r;
    fetch_addr_nxt_s    = fetch_addr_r;
    id_valid_nxt_s      = id_valid_r;
    id_instr_nxt_s      = id_instr_r;
    id_pc_plus4_nxt_s   = id_pc_plus4_r;
    skid_valid_nxt_s    = skid_valid_r;
    skid_instr_nxt_s    = skid_instr_r;
    skid_pc_plus4_nxt_s = skid_pc_plus4_r;

    // Decode takes the IF/ID entry; a waiting skid entry slides forward.
    if (consume_s) begin
      if (skid_valid_r) begin
        id_instr_nxt_s    = skid_instr_r;
        id_pc_plus4_nxt_s = skid_pc_plus4_r;
        skid_valid_nxt_s  = 1'b0;
      end else begin
        id_valid_nxt_s    = 1'b0;
      end
    end else begin
      id_valid_nxt_s = id_valid_r;
    end

    // Requests are only issued with the skid empty, so a response never
    // meets a full skid buffer.
    case (state_r)
      ST_FETCH: begin
        if (fire_s) begin
          state_nxt_s      = ST_WAIT;
          pc_nxt_s         = pc_inc(pc_r);
          fetch_addr_nxt_s = pc_r;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_nxt_s = ST_FETCH;
          if (!id_valid_r || id_ready) begin
            id_valid_nxt_s    = 1'b1;
            id_instr_nxt_s    = imem_rdata;
            id_pc_plus4_nxt_s = pc_inc(fetch_addr_r);
          end else begin
            skid_valid_nxt_s    = 1'b1;
            skid_instr_nxt_s    = imem_rdata;
            skid_pc_plus4_nxt_s = pc_inc(fetch_addr_r);
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase

    // A redirect flushes IF/ID and skid; any request still owed a response
    // must have that response swallowed in DROP.
    if (redirect_valid) begin
      pc_nxt_s         = redirect_pc & 32'hFFFF_FFFC;
      id_valid_nxt_s   = 1'b0;
      skid_valid_nxt_s = 1'b0;
      case (state_r)
        ST_FETCH: state_nxt_s = fire_s ? ST_DROP : ST_FETCH;
        ST_WAIT:  state_nxt_s = imem_rvalid ? ST_FETCH : ST_DROP;
        ST_DROP:  state_nxt_s = imem_rvalid ? ST_FETCH : ST_DROP;
        default:  state_nxt_s = ST_FETCH;
      endcase
    end else begin
      pc_nxt_s = pc_nxt_s;
    end

    imem_req_nxt_s = (state_nxt_s == ST_FETCH) && !skid_valid_nxt_s;
  end

  // State, PC, request and pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_FETCH;
      pc_r            <= RESET_PC;
      fetch_addr_r    <= 32'h0000_0000;
      imem_req_r      <= 1'b0;
      id_valid_r      <= 1'b0;
      id_instr_r      <= 32'h0000_0000;
      id_pc_plus4_r   <= 32'h0000_0000;
      skid_valid_r    <= 1'b0;
      skid_instr_r    <= 32'h0000_0000;
      skid_pc_plus4_r <= 32'h0000_0000;
    end else begin
      state_r         <= state_nxt_s;
      pc_r            <= pc_nxt_s;
      fetch_addr_r    <= fetch_addr_nxt_s;
      imem_req_r      <= imem_req_nxt_s;
      id_valid_r      <= id_valid_nxt_s;
      id_instr_r      <= id_instr_nxt_s;
      id_pc_plus4_r   <= id_pc_plus4_nxt_s;
      skid_valid_r    <= skid_valid_nxt_s;
      skid_instr_r    <= skid_instr_nxt_s;
      skid_pc_plus4_r <= skid_pc_plus4_nxt_s;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign id_valid    = id_valid_r;
  assign id_instr    = id_instr_r;
  assign id_pc_plus4 = id_pc_plus4_r;
  assign id_imm16    = id_instr_r[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a transaction-level model (expected fetch address,
// one in-flight request with a kill flag, and a queue of words owed to
// decode) is checked every cycle against the DUT under directed and random
// memory latency, grant, back-pressure and redirect traffic.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [15:0] id_imm16;

  // second instance exercising a non-zero reset PC at the top of memory
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_gnt;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_redirect;
  logic [31:0] w_rpc;
  logic        w_ready;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic [15:0] w_imm16;

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .id_imm16(id_imm16)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset_n(reset_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect), .redirect_pc(w_rpc),
    .id_ready(w_ready), .id_valid(w_valid), .id_instr(w_instr),
    .id_pc_plus4(w_pc4), .id_imm16(w_imm16)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] m_addr;
  logic [31:0] m_out_addr;
  bit          m_out;
  bit          m_kill;
  int          m_lat;

  logic        drv_gnt;
  logic        drv_ready;
  logic        drv_redirect;
  logic [31:0] drv_rpc;
  logic [31:0] drv_rdata;
  int          drv_lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_out  = 1'b0;
    m_kill = 1'b0;
    m_lat  = 0;
    m_addr = 32'h0000_0000;
  endtask

  // One clock: check outputs against the model, drive this cycle's inputs,
  // then advance the model by what the coming edge will do.
  task automatic cycle();
    logic exp_req;
    logic rv;
    logic grant;
    ent_t e;
    @(negedge clk);
    check_eq("id_valid", 32'(id_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_eq("id_instr", id_instr, exp_q[0].instr);
      check_eq("id_pc_plus4", id_pc_plus4, exp_q[0].pc4);
      check_eq("id_imm16", 32'(id_imm16), 32'(exp_q[0].instr[15:0]));
    end
    exp_req = !m_out && (exp_q.size() < 2);
    check_eq("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check_eq("imem_addr", imem_addr, m_addr);

    rv             = m_out && (m_lat == 1);
    imem_gnt       = drv_gnt;
    imem_rvalid    = rv;
    imem_rdata     = drv_rdata;
    id_ready       = drv_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_rpc;

    grant = exp_req && drv_gnt;
    if ((exp_q.size() > 0) && drv_ready) void'(exp_q.pop_front());
    if (m_out) begin
      if (rv) begin
        if (!m_kill) begin
          e.instr = drv_rdata;
          e.pc4   = m_out_addr + 32'd4;
          exp_q.push_back(e);
        end
        m_out = 1'b0;
      end else begin
        m_lat--;
      end
    end
    if (grant) begin
      m_out      = 1'b1;
      m_kill     = 1'b0;
      m_lat      = drv_lat;
      m_out_addr = m_addr;
      m_addr     = m_addr + 32'd4;
    end
    if (drv_redirect) begin
      exp_q.delete();
      if (m_out) m_kill = 1'b1;
      m_addr = drv_rpc & 32'hFFFF_FFFC;
    end
  endtask

  // Assert reset mid-cycle, check the async values, release on a falling edge
  // with an optional stray rvalid that must be ignored.
  task automatic do_reset(input logic stale_rv);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(id_valid), 32'd0);
    check_eq("rst_instr", id_instr, 32'd0);
    check_eq("rst_pc4", id_pc_plus4, 32'd0);
    check_eq("rst_imm16", 32'(id_imm16), 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    drv_gnt = 1'b0; drv_ready = 1'b0; drv_redirect = 1'b0; drv_rpc = 32'd0;
    @(negedge clk);
    reset_n     = 1'b1;
    imem_rvalid = stale_rv;
    imem_rdata  = 32'hDEAD_BEEF;
    model_reset();
  endtask

  initial begin
    int rdy_pct;
    reset_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'd0;
    w_redirect = 1'b0; w_rpc = 32'd0; w_ready = 1'b0;
    drv_gnt = 1'b0; drv_ready = 1'b0; drv_redirect = 1'b0;
    drv_rpc = 32'd0; drv_rdata = 32'd0; drv_lat = 1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // top-of-memory reset PC: pc+4 wraps to zero
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (w_req) break;
    end
    check_eq("w_req", 32'(w_req), 32'd1);
    check_eq("w_addr", w_addr, 32'hFFFF_FFFC);
    w_gnt = 1'b1;
    @(negedge clk);
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h2402_0005;
    @(negedge clk);
    w_rvalid = 1'b0;
    check_eq("w_valid", 32'(w_valid), 32'd1);
    check_eq("w_instr", w_instr, 32'h2402_0005);
    check_eq("w_pc4", w_pc4, 32'h0000_0000);
    check_eq("w_imm16", 32'(w_imm16), 32'h0000_0005);
    check_eq("w_next_addr", w_addr, 32'h0000_0000);

    // basic fetch, with a stray rvalid right after reset release
    do_reset(1'b1);
    drv_gnt = 1'b1; drv_ready = 1'b1; drv_lat = 1; drv_rdata = 32'h2010_FEDC;
    cycle();
    drv_gnt = 1'b0;
    cycle();
    drv_ready = 1'b0;
    cycle();
    check_eq("t1_instr", id_instr, 32'h2010_FEDC);
    check_eq("t1_imm16", 32'(id_imm16), 32'h0000_FEDC);
    check_eq("t1_pc4", id_pc_plus4, 32'h0000_0004);
    check_eq("t1_next_addr", imem_addr, 32'h0000_0004);

    // back-pressure: second word parks in the skid, requests stop
    do_reset(1'b0);
    drv_ready = 1'b0; drv_gnt = 1'b1; drv_lat = 1; drv_rdata = 32'h1111_1111;
    cycle();
    cycle();
    drv_rdata = 32'h2222_2222;
    cycle();
    cycle();
    repeat (3) cycle();
    check_eq("t2_stall_req", 32'(imem_req), 32'd0);
    check_eq("t2_first", id_instr, 32'h1111_1111);
    drv_ready = 1'b1; drv_gnt = 1'b0;
    cycle();
    drv_ready = 1'b0;
    cycle();
    check_eq("t2_second", id_instr, 32'h2222_2222);
    check_eq("t2_resume_req", 32'(imem_req), 32'd1);
    check_eq("t2_resume_addr", imem_addr, 32'h0000_0008);

    // redirect while waiting; late response dropped
    do_reset(1'b0);
    drv_gnt = 1'b1; drv_lat = 4; drv_ready = 1'b1; drv_rdata = 32'hAAAA_5555;
    cycle();
    drv_gnt = 1'b0; drv_redirect = 1'b1; drv_rpc = 32'h0000_0043;
    cycle();
    drv_redirect = 1'b0;
    repeat (3) cycle();
    cycle();
    check_eq("t3_dropped", 32'(id_valid), 32'd0);
    check_eq("t3_req", 32'(imem_req), 32'd1);
    check_eq("t3_addr", imem_addr, 32'h0000_0040);
    drv_gnt = 1'b1; drv_lat = 1; drv_ready = 1'b0; drv_rdata = 32'h0123_4567;
    cycle();
    drv_gnt = 1'b0;
    cycle();
    cycle();
    check_eq("t3_pc4", id_pc_plus4, 32'h0000_0044);

    // redirect in the same cycle as rvalid
    do_reset(1'b0);
    drv_gnt = 1'b1; drv_lat = 2; drv_ready = 1'b0; drv_rdata = 32'h3333_3333;
    cycle();
    drv_gnt = 1'b0;
    cycle();
    drv_redirect = 1'b1; drv_rpc = 32'h0000_0100;
    cycle();
    drv_redirect = 1'b0;
    cycle();
    check_eq("t4_dropped", 32'(id_valid), 32'd0);
    check_eq("t4_addr", imem_addr, 32'h0000_0100);

    // random traffic with a reset in the middle
    rdy_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 64) == 0) rdy_pct = int'($urandom_range(100, 5));
      if (i == 2000) do_reset(1'($urandom % 2));
      drv_gnt      = ($urandom % 4) != 0;
      drv_lat      = int'($urandom_range(4, 1));
      drv_rdata    = $urandom;
      drv_ready    = int'($urandom % 100) < rdy_pct;
      drv_redirect = ($urandom % 16) == 0;
      drv_rpc      = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      cycle();
    end
    drv_gnt = 1'b0; drv_redirect = 1'b0; drv_ready = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
